// File: rtl/uart_lite_pkg.sv
// uart_lite_pkg: shared deframer state encoding and parity-mode constants.
package uart_lite_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP, ST_RESYNC} state_e;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;
endpackage

// File: rtl/uart_deframer.sv
// uart_deframer: assembles UART frames from recovered bits and flags line errors.
module uart_deframer
  import uart_lite_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bit_i,
  input  logic                 bit_valid_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 break_o,
  output logic                 overrun_o
);
  localparam int IW = $clog2(DATA_BITS + 1);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic par_q, par_d, valid_q, valid_d;
  logic fe_q, fe_d, pe_q, pe_d, brk_q, brk_d, ovr_q, ovr_d;
  logic stop_ev, perr, good, load;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_ev = bit_valid_i && state_q == ST_STOP;
    perr    = PARITY != PARITY_NONE && ((^{shift_q, par_q}) != (PARITY == PARITY_ODD));
    brk_d   = stop_ev && !bit_i && shift_q == '0 && (PARITY == PARITY_NONE || !par_q);
    fe_d    = stop_ev && !bit_i && !brk_d;
    pe_d    = stop_ev && bit_i && perr;
    good    = stop_ev && bit_i && !perr;
    // a transfer in the completion cycle frees the slot, so no overrun then
    load    = good && !(valid_q && !ready_i);
    ovr_d   = good && valid_q && !ready_i;
    valid_d = load || (valid_q && !ready_i);
    data_d  = load ? shift_q : data_q;
    if (bit_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          state_d = bit_i ? ST_IDLE : ST_DATA;
          idx_d   = '0;
        end
        ST_DATA: begin
          shift_d = {bit_i, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IW'(1);
          if (idx_q == IW'(DATA_BITS - 1)) state_d = PARITY != PARITY_NONE ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          par_d   = bit_i;
          state_d = ST_STOP;
        end
        ST_STOP:   state_d = bit_i ? ST_IDLE : ST_RESYNC;
        ST_RESYNC: state_d = bit_i ? ST_IDLE : ST_RESYNC;
        default:   state_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    data_q  <= data_d;
  end
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign frame_err_o  = fe_q;
  assign parity_err_o = pe_q;
  assign break_o      = brk_q;
  assign overrun_o    = ovr_q;
endmodule
